// File: rtl/alu_uart_interface.sv
// Sequencer between UART rx/tx and the ALU: gathers A, B, opcode, returns result.
// Optional inter-byte timeout enabled by defining ALU_IF_TIMEOUT_EN.
module alu_uart_interface #(
  parameter int OPERAND_SIZE   = 8,
  parameter int OP_CODE_SIZE   = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [OPERAND_SIZE-1:0] i_rx_data,
  input  logic                    i_rx_done,
  input  logic                    i_tx_done,
  input  logic [OPERAND_SIZE-1:0] i_resultado,
  output logic [OPERAND_SIZE-1:0] o_dato_a,
  output logic [OPERAND_SIZE-1:0] o_dato_b,
  output logic [OP_CODE_SIZE-1:0] o_op_code,
  output logic [OPERAND_SIZE-1:0] o_tx_data,
  output logic                    o_tx_start,
  output logic                    o_busy,
  output logic                    o_drop
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    WAIT_TX
  } state_t;

  state_t state, state_nx;
  logic   timeout;
  logic   ld_a, ld_b, ld_op, ld_res, drop_nx;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

`ifdef ALU_IF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic             collecting;

  assign collecting = (state == WAIT_B) || (state == WAIT_OP);
  // An arriving byte always beats the timeout on the same cycle
  assign timeout = collecting && !i_rx_done &&
                   (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt <= '0;
    end else if (i_rx_done || !collecting || timeout) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= WAIT_A;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT_A: begin
        if (i_rx_done) state_nx = WAIT_B;
      end
      WAIT_B: begin
        if (i_rx_done)    state_nx = WAIT_OP;
        else if (timeout) state_nx = WAIT_A;
      end
      WAIT_OP: begin
        if (i_rx_done)    state_nx = EXEC;
        else if (timeout) state_nx = WAIT_A;
      end
      EXEC: begin
        state_nx = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) state_nx = WAIT_A;
      end
      default: begin
        state_nx = WAIT_A;
      end
    endcase
  end

  always_comb begin
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    ld_op   = 1'b0;
    ld_res  = 1'b0;
    drop_nx = 1'b0;
    unique case (state)
      WAIT_A:  ld_a  = i_rx_done;
      WAIT_B:  ld_b  = i_rx_done;
      WAIT_OP: ld_op = i_rx_done;
      EXEC: begin
        ld_res  = 1'b1;
        drop_nx = i_rx_done;
      end
      WAIT_TX: drop_nx = i_rx_done;
      default: ;
    endcase
  end

  assign o_busy = (state == EXEC) || (state == WAIT_TX);

  // Operands persist after a command so the ALU output stays stable on tx
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_dato_a   <= '0;
      o_dato_b   <= '0;
      o_op_code  <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_drop     <= 1'b0;
    end else begin
      if (ld_a)   o_dato_a  <= i_rx_data;
      if (ld_b)   o_dato_b  <= i_rx_data;
      if (ld_op)  o_op_code <= i_rx_data[OP_CODE_SIZE-1:0];
      if (ld_res) o_tx_data <= i_resultado;
      o_tx_start <= ld_res;
      o_drop     <= drop_nx;
    end
  end

endmodule

// File: doc/alu_uart_interface.md
Name: alu_uart_interface

Overview:
Command sequencer between the UART receiver/transmitter and the combinational ALU. It collects three received bytes in order: operand A, operand B, opcode. It presents them to the ALU, captures the ALU result one cycle later, and hands that result to the UART transmitter with a start pulse. It then waits for transmit completion before accepting the next command.

Parameters:
OPERAND_SIZE, 8, width of operands, result and UART data bytes
OP_CODE_SIZE, 6, width of ALU opcode; taken from the low bits of the opcode byte
TIMEOUT_CYCLES, 1000000, inter-byte timeout in clock cycles (used only with ALU_IF_TIMEOUT_EN)

Ports:
i_clk  input  1  system clock; all state changes on its rising edge
i_reset  input  1  asynchronous, active-high reset
i_rx_data  input  OPERAND_SIZE  byte from UART receiver; valid when i_rx_done=1
i_rx_done  input  1  one-cycle pulse per received byte
i_tx_done  input  1  one-cycle pulse when transmitter finishes a byte
i_resultado  input  OPERAND_SIZE  ALU result (combinational from o_dato_a/o_dato_b/o_op_code)
o_dato_a  output  OPERAND_SIZE  registered operand A to ALU
o_dato_b  output  OPERAND_SIZE  registered operand B to ALU
o_op_code  output  OP_CODE_SIZE  registered opcode to ALU
o_tx_data  output  OPERAND_SIZE  registered byte to transmitter
o_tx_start  output  1  one-cycle transmit request
o_busy  output  1  high in EXEC and WAIT_TX
o_drop  output  1  one-cycle pulse when a received byte is discarded

Behaviour:
- Reset (async, any state): state=WAIT_A. o_dato_a, o_dato_b, o_op_code, o_tx_data all 0; o_tx_start=0, o_busy=0, o_drop=0. Opcode 0 is the ALU reset opcode, so the ALU outputs 0.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, WAIT_TX.
- WAIT_A: on i_rx_done, o_dato_a<=i_rx_data; go to WAIT_B.
- WAIT_B: on i_rx_done, o_dato_b<=i_rx_data; go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_op_code<=i_rx_data[OP_CODE_SIZE-1:0]; upper bits are discarded with no check; go to EXEC.
- EXEC (exactly 1 cycle): o_tx_data<=i_resultado; o_tx_start<=1; go to WAIT_TX.
- WAIT_TX: o_tx_start is high only on its first cycle, then 0. On i_tx_done, go to WAIT_A.
- Latency: opcode byte accepted at edge E. The result is sampled at E+1. o_tx_start is high during the cycle after E+1.
- Operands and opcode hold their values until overwritten by the next command. The ALU output therefore stays stable during transmission.
- i_rx_done in EXEC or WAIT_TX: byte ignored, no register changes, o_drop pulses 1 cycle.
- i_rx_done and i_tx_done in the same cycle in WAIT_TX: go to WAIT_A, byte dropped (o_drop=1). The byte is not captured as A.
- i_tx_done outside WAIT_TX: ignored.
- o_tx_start is never asserted twice per command. No command is accepted until i_tx_done is seen.

Optional Feature:
ALU_IF_TIMEOUT_EN
- Defined: a counter clears on every i_rx_done and increments each cycle in WAIT_B or WAIT_OP. When it reaches TIMEOUT_CYCLES-1 without a byte, the FSM returns to WAIT_A and discards partial operands; o_dato_a/o_dato_b keep their last values. Counter is 0 on reset and in every other state. i_rx_done on the timeout cycle wins: the byte is accepted and the counter clears.
- Not defined: no counter; WAIT_B/WAIT_OP wait indefinitely.

Test Plan:
- Bytes 0x05, 0x03, 0x20 -> o_op_code=0x20; o_tx_data=0x08; o_tx_start pulses once, 2 cycles after the 3rd i_rx_done; then i_tx_done -> state WAIT_A.
- Bytes 0x03, 0x05, 0x22 (SUB) -> o_tx_data=0xFE; then 0xF0, 0x0F, 0xE7 -> o_op_code=0x27 (NOR, upper bits dropped) -> o_tx_data=0x00.
- Extra byte 0xAA pulsed during WAIT_TX -> o_drop=1 for one cycle; o_dato_a unchanged; next command 0x01, 0x01, 0x20 -> 0x02.
- Coincident i_rx_done and i_tx_done in WAIT_TX -> return to WAIT_A, o_drop=1, byte not latched as A.
- Assert i_reset after A, B received, mid-cycle -> outputs 0 immediately; new full command 0x0C, 0x0A, 0x24 -> 0x08.
- With ALU_IF_TIMEOUT_EN, TIMEOUT_CYCLES=16: send 0x07, then idle 16 cycles -> back to WAIT_A; next 0x02, 0x03, 0x20 -> 0x05. Without the macro, the same stimulus treats 0x02 as B.
